// File: rtl/rabbit_keystream_xor.sv
// rabbit_keystream_xor
//   Consumer end of the Rabbit state path. Requests a fresh internal state
//   (X0..X7) from the core, extracts the 128-bit keystream block from it and
//   XORs it, one 32-bit word at a time (word 0 first), onto a valid/ready
//   stream. The same path serves encryption and decryption.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   enable            permits new keystream requests from EMPTY
//   flush             synchronous discard of buffered keystream and output word
//   ks_req            one-cycle request for the core to step
//   state_valid, X0-7 core state presented in response to ks_req
//   in_valid/in_data/in_ready     input data stream
//   out_valid/out_data/out_ready  output data stream (in_data ^ keystream)
//   block_count       fully consumed keystream blocks, wraps at 2^CNT_W
module rabbit_keystream_xor #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  output logic             ks_req,
  input  logic             state_valid,
  input  logic [31:0]      X0,
  input  logic [31:0]      X1,
  input  logic [31:0]      X2,
  input  logic [31:0]      X3,
  input  logic [31:0]      X4,
  input  logic [31:0]      X5,
  input  logic [31:0]      X6,
  input  logic [31:0]      X7,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] block_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FULL} state_e;

  state_e             state_q, state_d;
  logic [127:0]       ks_q, ks_d;
  logic [1:0]         idx_q, idx_d;
  logic               ks_req_q, ks_req_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [127:0]       ks_new;
  logic [31:0]        ks_word;
  logic               accept;

  // Rabbit extraction: each 16-bit lane pairs an even state word with an
  // odd one, high half against low half.
  assign ks_new[15:0]    = X0[15:0]  ^ X5[31:16];
  assign ks_new[31:16]   = X0[31:16] ^ X3[15:0];
  assign ks_new[47:32]   = X2[15:0]  ^ X7[31:16];
  assign ks_new[63:48]   = X2[31:16] ^ X5[15:0];
  assign ks_new[79:64]   = X4[15:0]  ^ X1[31:16];
  assign ks_new[95:80]   = X4[31:16] ^ X7[15:0];
  assign ks_new[111:96]  = X6[15:0]  ^ X3[31:16];
  assign ks_new[127:112] = X6[31:16] ^ X1[15:0];

  assign ks_word = ks_q[{idx_q, 5'd0} +: 32];

  // Input is refused during flush so no word is silently swallowed.
  assign in_ready = (state_q == ST_FULL) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // ks_req is registered; flush masks it so a flush cycle never requests.
  assign ks_req      = ks_req_q && !flush;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign block_count = cnt_q;

  always_comb begin
    state_d     = state_q;
    ks_d        = ks_q;
    idx_d       = idx_q;
    ks_req_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      ks_d        = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (enable) begin
            ks_req_d = 1'b1;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (state_valid) begin
            ks_d    = ks_new;
            idx_d   = '0;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept) begin
            idx_d = 2'(idx_q + 2'd1);
            if (idx_q == 2'd3) begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_EMPTY;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      // Output register runs in every state so a pending word survives the
      // EMPTY/WAIT refill gap.
      if (accept) begin
        out_data_d  = in_data ^ ks_word;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      ks_q        <= '0;
      idx_q       <= '0;
      ks_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ks_q        <= ks_d;
      idx_q       <= idx_d;
      ks_req_q    <= ks_req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rabbit_keystream_xor.sv
module tb_rabbit_keystream_xor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        ks_req;
  logic        state_valid;
  logic [31:0] cur_st [8];
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [31:0] block_count;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned ks_cnt   = 0;
  logic [31:0] exp_q [$];
  int unsigned tx_cyc [$];

  rabbit_keystream_xor #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .flush       (flush),
    .ks_req      (ks_req),
    .state_valid (state_valid),
    .X0          (cur_st[0]),
    .X1          (cur_st[1]),
    .X2          (cur_st[2]),
    .X3          (cur_st[3]),
    .X4          (cur_st[4]),
    .X5          (cur_st[5]),
    .X6          (cur_st[6]),
    .X7          (cur_st[7]),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .block_count (block_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference keystream word k from the state currently held by the bench.
  function automatic logic [31:0] ks_word(input int unsigned k);
    logic [127:0] s;
    s[15:0]    = cur_st[0][15:0]  ^ cur_st[5][31:16];
    s[31:16]   = cur_st[0][31:16] ^ cur_st[3][15:0];
    s[47:32]   = cur_st[2][15:0]  ^ cur_st[7][31:16];
    s[63:48]   = cur_st[2][31:16] ^ cur_st[5][15:0];
    s[79:64]   = cur_st[4][15:0]  ^ cur_st[1][31:16];
    s[95:80]   = cur_st[4][31:16] ^ cur_st[7][15:0];
    s[111:96]  = cur_st[6][15:0]  ^ cur_st[3][31:16];
    s[127:112] = cur_st[6][31:16] ^ cur_st[1][15:0];
    return s[k*32 +: 32];
  endfunction

  // Output monitor: a transfer happens at the posedge following a negedge
  // where out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && ks_req) ks_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
        tx_cyc.push_back(cyc);
      end
    end
  end

  // Core model: answers each ks_req with a one-cycle state_valid.
  initial begin
    state_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ks_req) begin
        @(posedge clk); #1;
        state_valid = 1'b1;
        @(posedge clk); #1;
        state_valid = 1'b0;
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word; returns just after the handshake edge with in_valid
  // still asserted so calls can be chained back-to-back.
  task automatic send_word(input logic [31:0] d, input logic [31:0] e);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) exp_q.push_back(e);
    else check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  logic [31:0] w_zero [4] = '{32'h55557777, 32'h66660000, 32'h00000000, 32'h00003333};
  logic [31:0] w_ones [4] = '{32'hAAAA8888, 32'h9999FFFF, 32'hFFFFFFFF, 32'hFFFFCCCC};

  initial begin #400000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  initial begin
    int unsigned ks0;
    logic [31:0] d;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cur_st[i] = '0;
    cur_st[0] = 32'h11112222;
    cur_st[3] = 32'h33334444;
    cur_st[5] = 32'h55556666;

    step(2);
    check("rst_ks_req", {31'd0, ks_req}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_block_count", block_count, 32'd0);
    rst_n = 1'b1;

    // enable=0: no request, never ready
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("dis_ks_req", {31'd0, ks_req}, 32'd0);
      check("dis_in_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1);
    ks0 = ks_cnt;
    enable = 1'b1;
    step(10);
    check("en_one_ks_req", ks_cnt - ks0, 32'd1);

    // zero plaintext block
    for (int k = 0; k < 3; k++) send_word(32'h0, w_zero[k]);
    ks0 = ks_cnt;
    send_word(32'h0, w_zero[3]);
    idle();
    step(3);
    check("t1_block_count", block_count, 32'd1);
    check("t1_out_valid_idle", {31'd0, out_valid}, 32'd0);
    step(8);
    check("t1_next_ks_req", ks_cnt - ks0, 32'd1);

    // all-ones block, then round trip
    for (int k = 0; k < 4; k++) send_word(32'hFFFFFFFF, w_ones[k]);
    for (int k = 0; k < 4; k++) send_word(w_ones[k], 32'hFFFFFFFF);
    idle();
    step(3);
    check("t2_block_count", block_count, 32'd3);

    // backpressure then full-rate release
    out_ready = 1'b0;
    send_word(32'h0, w_zero[0]);
    in_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", out_data, 32'h55557777);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1);
    tx_cyc.delete();
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) send_word(32'h0, w_zero[k]);
    idle();
    step(3);
    check("bp_tx_count", 32'(tx_cyc.size()), 32'd4);
    if (tx_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("bp_no_gap", tx_cyc[i] - tx_cyc[i-1], 32'd1);
    check("t3_block_count", block_count, 32'd4);

    // flush after two words
    send_word(32'h0, w_zero[0]);
    send_word(32'h0, w_zero[1]);
    idle();
    out_ready = 1'b0;
    @(negedge clk);
    check("fl_pending_valid", {31'd0, out_valid}, 32'd1);
    step(1);
    ks0 = ks_cnt;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step(8);
    check("fl_new_ks_req", ks_cnt - ks0, 32'd1);
    check("fl_block_count", block_count, 32'd4);
    for (int k = 0; k < 4; k++) send_word(32'h0, w_zero[k]);
    idle();
    step(3);
    check("fl_block_done", block_count, 32'd5);

    // async reset mid-block
    out_ready = 1'b0;
    send_word(32'h12345678, 32'h12345678 ^ 32'h55557777);
    idle();
    @(negedge clk);
    check("rr_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_ks_req", {31'd0, ks_req}, 32'd0);
    check("rr_in_ready", {31'd0, in_ready}, 32'd0);
    check("rr_out_valid", {31'd0, out_valid}, 32'd0);
    check("rr_out_data", out_data, 32'd0);
    check("rr_block_count", block_count, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) cur_st[i] = $urandom;
    step(2);
    ks0 = ks_cnt;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(8);
    check("rr_ks_req_again", ks_cnt - ks0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      send_word(d, d ^ ks_word(k));
    end
    idle();
    step(4);
    check("rr_block_count_after", block_count, 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rabbit_keystream_xor.md
Name: rabbit_keystream_xor

Overview:
Consumer end of the Rabbit state path. Requests a new internal state (X0..X7) from the core and extracts the 128-bit keystream block from it. It then XORs that keystream, one 32-bit word at a time, onto a valid/ready data stream, so the same block serves both encryption and decryption. It sits between the Rabbit core (after key/IV setup) and the datapath payload interface.

Parameters:
CNT_W, 32, width of the consumed-keystream-block counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  allows keystream requests; 0 inhibits new ks_req only
flush  input  1  sync discard of buffered keystream and output word (e.g. after a new IV)
ks_req  output  1  one-cycle pulse: core must step and present the next state
state_valid  input  1  X0..X7 valid this cycle, in response to ks_req
X0..X7  input  32 each  Rabbit state variables
in_valid  input  1  input data word valid
in_data  input  32  plaintext/ciphertext word
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  out_data valid
out_data  output  32  in_data XOR keystream word
out_ready  input  1  downstream accepts out_data
block_count  output  CNT_W  number of fully consumed keystream blocks, wraps

Behaviour:
- Reset (rst_n=0, async):
  - ks_req=0, in_ready=0, out_valid=0, out_data=0, block_count=0.
  - Keystream register=0, word index=0, FSM=EMPTY.
- Keystream extraction, latched on the cycle state_valid=1 in WAIT:
  - S[15:0]=X0[15:0]^X5[31:16]
  - S[31:16]=X0[31:16]^X3[15:0]
  - S[47:32]=X2[15:0]^X7[31:16]
  - S[63:48]=X2[31:16]^X5[15:0]
  - S[79:64]=X4[15:0]^X1[31:16]
  - S[95:80]=X4[31:16]^X7[15:0]
  - S[111:96]=X6[15:0]^X3[31:16]
  - S[127:112]=X6[31:16]^X1[15:0]
- Word order: word k = S[32k+31:32k], k=0..3, consumed in ascending order.
- FSM:
  - EMPTY: if enable=1, assert ks_req for exactly one cycle and go to WAIT; otherwise stay.
  - WAIT: ks_req=0. On state_valid=1, latch S, clear index to 0, go to FULL. state_valid outside WAIT is ignored.
  - FULL: in_ready=(!out_valid || out_ready).
    - On in_valid&&in_ready: out_data<=in_data^word[idx], out_valid<=1, idx<=idx+1.
    - If idx was 3: block_count<=block_count+1 (wraps at 2^CNT_W), go to EMPTY.
- in_ready is 0 in EMPTY and WAIT.
- Latency: one cycle from input handshake to out_valid.
- Output register:
  - out_valid clears on out_ready when no new word loads in the same cycle.
  - Simultaneous out_ready and an input handshake reload it back-to-back, giving full throughput within a block.
  - out_data holds while out_valid=1 and out_ready=0.
- Block boundary: EMPTY→WAIT→FULL costs at least 2 cycles of in_ready=0 plus the core's response time. The pending out word stays valid throughout.
- flush: highest priority, synchronous.
  - Next state is EMPTY, idx=0, out_valid=0, ks_req=0 that cycle.
  - Any partially used keystream is discarded; block_count is unchanged.
  - A state_valid coincident with flush is dropped.
- enable falling while in WAIT or FULL does not abort; it only blocks the next request from EMPTY.
- Reset mid-block: everything returns to reset values immediately. The next block starts with a fresh ks_req.

Test Plan:
1. State X0=0x11112222, X3=0x33334444, X5=0x55556666, others 0; four input words of 0x00000000 → out_data 0x55557777, 0x66660000, 0x00000000, 0x00003333; block_count=1; then one ks_req pulse.
2. Same state, inputs 0xFFFFFFFF → outputs 0xAAAA8888, 0x9999FFFF, 0xFFFFFFFF, 0xFFFFCCCC. Feeding these outputs back in with the same state recovers 0xFFFFFFFF (round trip).
3. Hold out_ready=0 after the first word → out_data stays 0x55557777, in_ready=0. Release → remaining words stream with no gaps and no drops.
4. Assert flush after 2 words → out_valid=0 next cycle, new ks_req. The next input is XORed with word0 of the new block; block_count unchanged.
5. enable=0 from reset → ks_req never pulses and in_ready stays 0. Raise enable → exactly one ks_req pulse.
6. Drop rst_n in FULL with out_valid=1 → all outputs 0 asynchronously. After release, the EMPTY→WAIT handshake repeats.
